// File: rtl/async_reset_pkg.sv
// Shared constants for the reset synchroniser.
`timescale 1ns/10ps
package async_reset_pkg;

   localparam int unsigned STAGES_MIN = 2;
   localparam int unsigned STAGES_MAX = 8;

   function automatic logic stages_ok(input int unsigned n);
      return (n >= STAGES_MIN) && (n <= STAGES_MAX);
   endfunction

endpackage

// File: rtl/async_reset.sv
// Reset synchroniser: asynchronous assert, release aligned to the STAGES-th
// rising edge of i_clk after i_rst falls.
`timescale 1ns/10ps
module async_reset
   import async_reset_pkg::*;
#(
   parameter int unsigned STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   output logic o_rst
);

   if (!stages_ok(STAGES)) begin : g_bad_stages
      $error("async_reset: STAGES must be within 2..8");
   end

   // Chain powers up asserted so o_rst is high from time zero without a pulse.
   (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q = '1;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], 1'b0};
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sync_q <= '1;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign o_rst = sync_q[STAGES-1];

`ifndef SYNTHESIS
   a_rst_holds: assert property (@(posedge i_clk) i_rst |-> o_rst);

   always @(negedge o_rst) begin
      a_release_on_edge: assert (i_clk && !i_rst);
   end
`endif

endmodule

// File: tb/tb_async_reset.sv
// Scoreboard bench for async_reset, STAGES=2 and STAGES=3 side by side on a
// shared clock and reset request.
`timescale 1ns/10ps
module tb_async_reset;

   logic i_clk = 1'b1;
   logic i_rst = 1'b0;
   logic o_rst_s2;
   logic o_rst_s3;
   bit   clk_en = 1'b1;

   int unsigned checks = 0;
   int unsigned errors = 0;

   typedef struct {
      string   tag;
      realtime t;
      logic    e2;
      logic    e3;
   } exp_t;

   exp_t sb[$];

   async_reset #(.STAGES(2)) dut_s2 (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .o_rst (o_rst_s2)
   );

   async_reset #(.STAGES(3)) dut_s3 (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .o_rst (o_rst_s3)
   );

   // Rising edges at 10, 20, ...; while clk_en is low the clock parks high.
   always begin
      #5;
      if (clk_en) i_clk = ~i_clk;
   end

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $realtime);
      end
   endtask

   task automatic expect_at(input string tag, input realtime t, input logic e2, input logic e3);
      exp_t e;
      e.tag = tag;
      e.t   = t;
      e.e2  = e2;
      e.e3  = e3;
      sb.push_back(e);
   endtask

   task automatic at_time(input realtime t);
      if (t > $realtime) #(t - $realtime);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         while (sb.size() == 0) #1;
         e = sb[0];
         if (e.t > $realtime) #(e.t - $realtime);
         chk({e.tag, "_s2"}, o_rst_s2, e.e2);
         chk({e.tag, "_s3"}, o_rst_s3, e.e3);
         void'(sb.pop_front());
      end
   end

   initial begin : stimulus
      int unsigned n;

      // power-up with i_rst low throughout
      expect_at("pwr_t1",  1.0,  1'b1, 1'b1);
      expect_at("pwr_t15", 15.0, 1'b1, 1'b1);
      expect_at("pwr_t25", 25.0, 1'b0, 1'b1);
      expect_at("pwr_t28", 28.0, 1'b0, 1'b1);
      expect_at("pwr_t35", 35.0, 1'b0, 1'b0);

      // multi-cycle assertion, release counted from edges after the fall
      expect_at("long_rise", 43.5,  1'b1, 1'b1);
      expect_at("long_hold", 55.0,  1'b1, 1'b1);
      expect_at("long_fall", 70.5,  1'b1, 1'b1);
      expect_at("long_e1",   85.0,  1'b1, 1'b1);
      expect_at("long_e2",   95.0,  1'b0, 1'b1);
      expect_at("long_e3",   105.0, 1'b0, 1'b0);
      at_time(43.14); i_rst = 1'b1;
      at_time(70.33); i_rst = 1'b0;

      // assertion between edges is seen immediately, not at the next edge
      expect_at("mid_pre",  110.2, 1'b0, 1'b0);
      expect_at("mid_rise", 110.5, 1'b1, 1'b1);
      expect_at("mid_hold", 121.0, 1'b1, 1'b1);
      expect_at("mid_e1",   135.0, 1'b1, 1'b1);
      expect_at("mid_e2",   145.0, 1'b0, 1'b1);
      expect_at("mid_e3",   155.0, 1'b0, 1'b0);
      at_time(110.33); i_rst = 1'b1;
      at_time(125.33); i_rst = 1'b0;

      // 1 ns pulse with no clock edge inside it
      expect_at("pulse_pre", 161.0, 1'b0, 1'b0);
      expect_at("pulse_in",  162.5, 1'b1, 1'b1);
      expect_at("pulse_aft", 165.0, 1'b1, 1'b1);
      expect_at("pulse_e1",  175.0, 1'b1, 1'b1);
      expect_at("pulse_e2",  185.0, 1'b0, 1'b1);
      expect_at("pulse_e3",  195.0, 1'b0, 1'b0);
      at_time(162.0); i_rst = 1'b1;
      at_time(163.0); i_rst = 1'b0;

      // re-assert after one release edge: count must start over
      expect_at("re_first",  212.0, 1'b1, 1'b1);
      expect_at("re_again",  213.5, 1'b1, 1'b1);
      expect_at("re_e1",     225.0, 1'b1, 1'b1);
      expect_at("re_e2",     235.0, 1'b0, 1'b1);
      expect_at("re_e3",     245.0, 1'b0, 1'b0);
      at_time(202.0); i_rst = 1'b1;
      at_time(205.0); i_rst = 1'b0;
      at_time(213.0); i_rst = 1'b1;
      at_time(216.0); i_rst = 1'b0;

      // clock parked high from 250; pulse while stopped, resume with edges at 310, 320, 330
      expect_at("stop_pre",  259.0, 1'b0, 1'b0);
      expect_at("stop_rise", 261.0, 1'b1, 1'b1);
      expect_at("stop_h280", 280.0, 1'b1, 1'b1);
      expect_at("stop_h300", 300.0, 1'b1, 1'b1);
      expect_at("stop_e1",   315.0, 1'b1, 1'b1);
      expect_at("stop_e2",   325.0, 1'b0, 1'b1);
      expect_at("stop_e3",   335.0, 1'b0, 1'b0);
      at_time(252.0); clk_en = 1'b0;
      at_time(260.0); i_rst  = 1'b1;
      at_time(270.0); i_rst  = 1'b0;
      at_time(302.0); clk_en = 1'b1;

      n = 0;
      while (sb.size() != 0 && n < 2000) begin
         #1;
         n++;
      end
      chk("sb_drain", sb.size() == 0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
